// File: rtl/bp_me_pkg.sv
// Shared definitions for the memory-endpoint coordinate-to-id map.
// Holds the bp_me_defines macros: the parameterised region entry struct
// bp_me_cord_region_s and its packed width macro, plus package helpers.
`ifndef BP_ME_DEFINES_SVH
`define BP_ME_DEFINES_SVH

// Packed region entry, MSB first: v, x_lo, y_lo, x_dim, y_dim, col_major,
// two_lce, cce_base, lce_base.
`define DECLARE_BP_ME_CORD_REGION_S(x_w, y_w, id_w) \
  typedef struct packed {                            \
    logic            v;                              \
    logic [x_w-1:0]  x_lo;                           \
    logic [y_w-1:0]  y_lo;                           \
    logic [x_w-1:0]  x_dim;                          \
    logic [y_w-1:0]  y_dim;                          \
    logic            col_major;                      \
    logic            two_lce;                        \
    logic [id_w-1:0] cce_base;                       \
    logic [id_w-1:0] lce_base;                       \
  } bp_me_cord_region_s

`define BP_ME_CORD_REGION_WIDTH(x_w, y_w, id_w) (3 + 2*(x_w) + 2*(y_w) + 2*(id_w))

`endif

package bp_me_pkg;

  // Index width for a table of n regions, never narrower than one bit.
  function automatic int unsigned region_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bp_me_cord_region_match.sv
// Combinational match of one coordinate against one region entry.
// Produces the hit bit, the local index inside the region and the entry
// fields the id computation needs.
module bp_me_cord_region_match
  import bp_me_pkg::*;
#(
  parameter int unsigned x_cord_width_p = 4,
  parameter int unsigned y_cord_width_p = 4,
  parameter int unsigned id_width_p     = 6,
  localparam int unsigned entry_width_lp =
    `BP_ME_CORD_REGION_WIDTH(x_cord_width_p, y_cord_width_p, id_width_p)
) (
  input  logic [entry_width_lp-1:0] entry_i,
  input  logic [x_cord_width_p-1:0] x_i,
  input  logic [y_cord_width_p-1:0] y_i,
  output logic                      hit_o,
  output logic [id_width_p-1:0]     idx_o,
  output logic                      two_lce_o,
  output logic [id_width_p-1:0]     cce_base_o,
  output logic [id_width_p-1:0]     lce_base_o
);

  `DECLARE_BP_ME_CORD_REGION_S(x_cord_width_p, y_cord_width_p, id_width_p);

  bp_me_cord_region_s entry;
  logic [x_cord_width_p:0]   x_end;
  logic [y_cord_width_p:0]   y_end;
  logic [x_cord_width_p-1:0] lx;
  logic [y_cord_width_p-1:0] ly;
  logic [id_width_p-1:0]     row_idx;
  logic [id_width_p-1:0]     col_idx;

  assign entry = entry_i;

  // One extra bit so a region touching the mesh edge does not wrap around.
  assign x_end = {1'b0, entry.x_lo} + {1'b0, entry.x_dim};
  assign y_end = {1'b0, entry.y_lo} + {1'b0, entry.y_dim};

  assign hit_o = entry.v
               & (x_i >= entry.x_lo) & ({1'b0, x_i} < x_end)
               & (y_i >= entry.y_lo) & ({1'b0, y_i} < y_end);

  assign lx = x_i - entry.x_lo;
  assign ly = y_i - entry.y_lo;

  // Ids are taken modulo 2^id_width_p, so the index only needs that width.
  assign row_idx = id_width_p'(lx) + id_width_p'(entry.x_dim) * id_width_p'(ly);
  assign col_idx = id_width_p'(ly) + id_width_p'(entry.y_dim) * id_width_p'(lx);

  assign idx_o      = entry.col_major ? col_idx : row_idx;
  assign two_lce_o  = entry.two_lce;
  assign cce_base_o = entry.cce_base;
  assign lce_base_o = entry.lce_base;

endmodule

// File: rtl/bp_me_cord_id_map.sv
// Programmable mesh-coordinate to CCE/LCE id translator.
// Two-stage pipeline: stage 1 registers the winning region and local index,
// stage 2 registers the final ids. Valid/ready on both sides.
// Optional feature macro: BP_ME_CORD_ID_MAP_MULTI_HIT_EN (reports overlaps).
module bp_me_cord_id_map
  import bp_me_pkg::*;
#(
  parameter int unsigned x_cord_width_p = 4,
  parameter int unsigned y_cord_width_p = 4,
  parameter int unsigned id_width_p     = 6,
  parameter int unsigned num_regions_p  = 5,
  localparam int unsigned region_width_lp = region_width(num_regions_p),
  localparam int unsigned cord_width_lp   = x_cord_width_p + y_cord_width_p,
  localparam int unsigned entry_width_lp  =
    `BP_ME_CORD_REGION_WIDTH(x_cord_width_p, y_cord_width_p, id_width_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [cord_width_lp-1:0]   cord_i,
  input  logic                       cord_v_i,
  output logic                       cord_ready_and_o,
  output logic [id_width_p-1:0]      cce_id_o,
  output logic [id_width_p-1:0]      lce_id0_o,
  output logic [id_width_p-1:0]      lce_id1_o,
  output logic                       miss_o,
  output logic                       multi_hit_o,
  output logic [region_width_lp-1:0] region_o,
  output logic                       id_v_o,
  input  logic                       id_ready_and_i,
  input  logic                       cfg_w_v_i,
  input  logic [region_width_lp-1:0] cfg_addr_i,
  input  logic [entry_width_lp-1:0]  cfg_data_i
);

  localparam logic [region_width_lp:0] num_regions_lp = (region_width_lp + 1)'(num_regions_p);

  logic [entry_width_lp-1:0] table_q [num_regions_p];
  logic                      cfg_in_range;

  logic [num_regions_p-1:0]  hit;
  logic [num_regions_p-1:0]  two_lce;
  logic [id_width_p-1:0]     idx      [num_regions_p];
  logic [id_width_p-1:0]     cce_base [num_regions_p];
  logic [id_width_p-1:0]     lce_base [num_regions_p];

  logic                       win_v;
  logic [region_width_lp-1:0] win_region;
  logic [id_width_p-1:0]      win_idx;
  logic                       win_two_lce;
  logic [id_width_p-1:0]      win_cce_base;
  logic [id_width_p-1:0]      win_lce_base;

  logic                       s1_en;
  logic                       s2_en;
  logic                       accept;

  logic                       s1_v_q;
  logic                       s1_miss_q;
  logic [region_width_lp-1:0] s1_region_q;
  logic [id_width_p-1:0]      s1_idx_q;
  logic                       s1_two_lce_q;
  logic [id_width_p-1:0]      s1_cce_base_q;
  logic [id_width_p-1:0]      s1_lce_base_q;

  logic [id_width_p-1:0]      lce0_next;
  logic [id_width_p-1:0]      lce1_next;

  logic                       s2_v_q;
  logic                       s2_miss_q;
  logic [region_width_lp-1:0] s2_region_q;
  logic [id_width_p-1:0]      s2_cce_q;
  logic [id_width_p-1:0]      s2_lce0_q;
  logic [id_width_p-1:0]      s2_lce1_q;

  assign cfg_in_range = ({1'b0, cfg_addr_i} < num_regions_lp);

  // Region table: writes land at the edge, so a same-cycle lookup sees the old entry.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < int'(num_regions_p); i++) begin
        table_q[i] <= '0;
      end
    end else if (cfg_w_v_i && cfg_in_range) begin
      table_q[cfg_addr_i] <= cfg_data_i;
    end
  end

  for (genvar g = 0; g < int'(num_regions_p); g++) begin : g_region
    bp_me_cord_region_match #(
      .x_cord_width_p (x_cord_width_p),
      .y_cord_width_p (y_cord_width_p),
      .id_width_p     (id_width_p)
    ) u_match (
      .entry_i    (table_q[g]),
      .x_i        (cord_i[x_cord_width_p-1:0]),
      .y_i        (cord_i[cord_width_lp-1:x_cord_width_p]),
      .hit_o      (hit[g]),
      .idx_o      (idx[g]),
      .two_lce_o  (two_lce[g]),
      .cce_base_o (cce_base[g]),
      .lce_base_o (lce_base[g])
    );
  end

  // Priority select: scanning downward leaves the lowest matching index as winner.
  always_comb begin
    win_v        = 1'b0;
    win_region   = '0;
    win_idx      = '0;
    win_two_lce  = 1'b0;
    win_cce_base = '0;
    win_lce_base = '0;
    for (int i = int'(num_regions_p) - 1; i >= 0; i--) begin
      if (hit[i]) begin
        win_v        = 1'b1;
        win_region   = region_width_lp'(i);
        win_idx      = idx[i];
        win_two_lce  = two_lce[i];
        win_cce_base = cce_base[i];
        win_lce_base = lce_base[i];
      end
    end
  end

  assign s2_en            = ~s2_v_q | id_ready_and_i;
  assign s1_en            = ~s1_v_q | s2_en;
  assign cord_ready_and_o = s1_en;
  assign accept           = cord_v_i & s1_en;

  // Stage 1: capture winner, index and bases so later cfg writes cannot disturb it.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s1_v_q        <= 1'b0;
      s1_miss_q     <= 1'b0;
      s1_region_q   <= '0;
      s1_idx_q      <= '0;
      s1_two_lce_q  <= 1'b0;
      s1_cce_base_q <= '0;
      s1_lce_base_q <= '0;
    end else if (s1_en) begin
      s1_v_q <= cord_v_i;
      if (accept) begin
        // A miss zeroes everything so stage 2 naturally produces all-zero ids.
        s1_miss_q     <= ~win_v;
        s1_region_q   <= win_region;
        s1_idx_q      <= win_idx;
        s1_two_lce_q  <= win_two_lce;
        s1_cce_base_q <= win_cce_base;
        s1_lce_base_q <= win_lce_base;
      end
    end
  end

  // Final id arithmetic, all modulo 2^id_width_p.
  always_comb begin
    lce0_next = s1_lce_base_q + (s1_two_lce_q ? (s1_idx_q << 1) : s1_idx_q);
    lce1_next = lce0_next + id_width_p'(s1_two_lce_q);
  end

  // Stage 2: output registers, held while the consumer stalls.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s2_v_q      <= 1'b0;
      s2_miss_q   <= 1'b0;
      s2_region_q <= '0;
      s2_cce_q    <= '0;
      s2_lce0_q   <= '0;
      s2_lce1_q   <= '0;
    end else if (s2_en) begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        s2_miss_q   <= s1_miss_q;
        s2_region_q <= s1_region_q;
        s2_cce_q    <= s1_cce_base_q + s1_idx_q;
        s2_lce0_q   <= lce0_next;
        s2_lce1_q   <= lce1_next;
      end
    end
  end

`ifdef BP_ME_CORD_ID_MAP_MULTI_HIT_EN
  logic multi;
  logic s1_multi_q;
  logic s2_multi_q;

  // Two or more set bits: clearing the lowest one still leaves something.
  assign multi = |(hit & (hit - num_regions_p'(1)));

  // Overlap flag travels alongside the lookup through both stages.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s1_multi_q <= 1'b0;
      s2_multi_q <= 1'b0;
    end else begin
      if (accept) begin
        s1_multi_q <= multi;
      end
      if (s2_en && s1_v_q) begin
        s2_multi_q <= s1_multi_q;
      end
    end
  end

  assign multi_hit_o = s2_multi_q;
`else
  assign multi_hit_o = 1'b0;
`endif

  assign id_v_o    = s2_v_q;
  assign miss_o    = s2_miss_q;
  assign region_o  = s2_region_q;
  assign cce_id_o  = s2_cce_q;
  assign lce_id0_o = s2_lce0_q;
  assign lce_id1_o = s2_lce1_q;

endmodule

// File: tb/tb_bp_me_cord_id_map.sv
// Self-checking bench for bp_me_cord_id_map (default parameters).
// A negedge monitor pushes the expected response for every accepted lookup,
// using a bench-side table model updated from observed cfg writes.
module tb_bp_me_cord_id_map;

  localparam int NR = 5;
  typedef logic [22:0] resp_t;  // {cce, lce0, lce1, miss, multi, region}

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [7:0]  cord_i;
  logic        cord_v_i;
  logic        cord_ready_and_o;
  logic [5:0]  cce_id_o;
  logic [5:0]  lce_id0_o;
  logic [5:0]  lce_id1_o;
  logic        miss_o;
  logic        multi_hit_o;
  logic [2:0]  region_o;
  logic        id_v_o;
  logic        id_ready_and_i;
  logic        cfg_w_v_i;
  logic [2:0]  cfg_addr_i;
  logic [30:0] cfg_data_i;

  always #5 clk_i = ~clk_i;

  bp_me_cord_id_map dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .cord_i           (cord_i),
    .cord_v_i         (cord_v_i),
    .cord_ready_and_o (cord_ready_and_o),
    .cce_id_o         (cce_id_o),
    .lce_id0_o        (lce_id0_o),
    .lce_id1_o        (lce_id1_o),
    .miss_o           (miss_o),
    .multi_hit_o      (multi_hit_o),
    .region_o         (region_o),
    .id_v_o           (id_v_o),
    .id_ready_and_i   (id_ready_and_i),
    .cfg_w_v_i        (cfg_w_v_i),
    .cfg_addr_i       (cfg_addr_i),
    .cfg_data_i       (cfg_data_i)
  );

  int    n_cmp = 0;
  int    n_err = 0;
  resp_t q[$];
  bit    mh_en;

  int tv[NR], txl[NR], tyl[NR], txd[NR], tyd[NR], tcm[NR], ttl[NR], tcb[NR], tlb[NR];

  function automatic void clear_model();
    for (int i = 0; i < NR; i++) begin
      tv[i] = 0; txl[i] = 0; tyl[i] = 0; txd[i] = 0; tyd[i] = 0;
      tcm[i] = 0; ttl[i] = 0; tcb[i] = 0; tlb[i] = 0;
    end
  endfunction

  function automatic resp_t model(input int x, input int y);
    int hits = 0;
    int win = -1;
    int lx, ly, idx, cce, l0, l1;
    for (int i = 0; i < NR; i++) begin
      if (tv[i] != 0 && x >= txl[i] && x < txl[i] + txd[i] && y >= tyl[i] && y < tyl[i] + tyd[i]) begin
        hits++;
        if (win < 0) win = i;
      end
    end
    if (win < 0) return {18'd0, 1'b1, 1'b0, 3'd0};
    lx  = x - txl[win];
    ly  = y - tyl[win];
    idx = (tcm[win] != 0) ? ly + tyd[win] * lx : lx + txd[win] * ly;
    cce = (tcb[win] + idx) % 64;
    l0  = (tlb[win] + (idx << ttl[win])) % 64;
    l1  = (ttl[win] != 0) ? (l0 + 1) % 64 : l0;
    return {6'(cce), 6'(l0), 6'(l1), 1'b0, (mh_en && hits > 1), 3'(win)};
  endfunction

  function automatic resp_t get_resp();
    return {cce_id_o, lce_id0_o, lce_id1_o, miss_o, multi_hit_o, region_o};
  endfunction

  function automatic logic [30:0] pack(input logic v, input logic [3:0] xl, input logic [3:0] yl,
                                       input logic [3:0] xd, input logic [3:0] yd,
                                       input logic cm, input logic tl,
                                       input logic [5:0] cb, input logic [5:0] lb);
    return {v, xl, yl, xd, yd, cm, tl, cb, lb};
  endfunction

  // Monitor: record expectation of each accepted lookup, then apply cfg writes.
  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (cord_v_i && cord_ready_and_o) q.push_back(model(int'(cord_i[3:0]), int'(cord_i[7:4])));
      if (cfg_w_v_i && cfg_addr_i < NR) begin
        int a;
        a = int'(cfg_addr_i);
        tv[a]  = int'(cfg_data_i[30]);
        txl[a] = int'(cfg_data_i[29:26]);
        tyl[a] = int'(cfg_data_i[25:22]);
        txd[a] = int'(cfg_data_i[21:18]);
        tyd[a] = int'(cfg_data_i[17:14]);
        tcm[a] = int'(cfg_data_i[13]);
        ttl[a] = int'(cfg_data_i[12]);
        tcb[a] = int'(cfg_data_i[11:6]);
        tlb[a] = int'(cfg_data_i[5:0]);
      end
    end
  end

  task automatic do_reset();
    reset_i        = 1'b1;
    cord_i         = '0;
    cord_v_i       = 1'b0;
    id_ready_and_i = 1'b1;
    cfg_w_v_i      = 1'b0;
    cfg_addr_i     = '0;
    cfg_data_i     = '0;
    q.delete();
    clear_model();
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b0;
  endtask

  task automatic cfg_write(input logic [2:0] addr, input logic [30:0] data);
    cfg_w_v_i  = 1'b1;
    cfg_addr_i = addr;
    cfg_data_i = data;
    @(posedge clk_i);
    #1 cfg_w_v_i = 1'b0;
  endtask

  task automatic lookup(input int x, input int y);
    bit ok = 0;
    cord_i   = {4'(y), 4'(x)};
    cord_v_i = 1'b1;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk_i);
      if (cord_ready_and_o) ok = 1;
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL lookup_accept_timeout: ready=%b required 1", cord_ready_and_o);
    end
    @(posedge clk_i);
    #1 cord_v_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk_i);
    n_cmp++;
    if (cord_ready_and_o !== 1'b1) begin
      n_err++; $display("FAIL reset_ready: got %b required 1", cord_ready_and_o);
    end
    n_cmp++;
    if (id_v_o !== 1'b0) begin
      n_err++; $display("FAIL reset_id_v: got %b required 0", id_v_o);
    end
    n_cmp++;
    if (get_resp() !== resp_t'(0)) begin
      n_err++; $display("FAIL reset_outputs: got %h required 0", get_resp());
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_basic();
    int got_n = 0;
    resp_t exp;
    cfg_write(3'd0, pack(1'b1, 4'd1, 4'd1, 4'd2, 4'd2, 1'b0, 1'b1, 6'd0, 6'd0));
    lookup(2, 2);
    for (int c = 0; c < 20 && got_n < 1; c++) begin
      @(negedge clk_i);
      if (id_v_o) begin
        exp = (q.size() > 0) ? q.pop_front() : 'x;
        n_cmp++;
        if (get_resp() !== exp) begin
          n_err++; $display("FAIL basic_model: got %h required %h", get_resp(), exp);
        end
        n_cmp++;
        if (get_resp() !== {6'd3, 6'd6, 6'd7, 1'b0, 1'b0, 3'd0}) begin
          n_err++; $display("FAIL basic_vector: got %h required cce3 lce6/7 hit r0", get_resp());
        end
        got_n++;
      end
      @(posedge clk_i);
      #1;
    end
    if (got_n < 1) begin
      n_cmp++; n_err++; $display("FAIL basic_timeout: got %0d responses required 1", got_n);
    end
  endtask

  task automatic test_miss();
    int got_n = 0;
    resp_t exp;
    lookup(0, 0);
    for (int c = 0; c < 20 && got_n < 1; c++) begin
      @(negedge clk_i);
      if (id_v_o) begin
        exp = (q.size() > 0) ? q.pop_front() : 'x;
        n_cmp++;
        if (get_resp() !== exp) begin
          n_err++; $display("FAIL miss_model: got %h required %h", get_resp(), exp);
        end
        n_cmp++;
        if (get_resp() !== {18'd0, 1'b1, 1'b0, 3'd0}) begin
          n_err++; $display("FAIL miss_vector: got %h required miss with zero ids", get_resp());
        end
        got_n++;
      end
      @(posedge clk_i);
      #1;
    end
    if (got_n < 1) begin
      n_cmp++; n_err++; $display("FAIL miss_timeout: got %0d responses required 1", got_n);
    end
  endtask

  task automatic test_back_to_back();
    int got_n = 0;
    resp_t exp;
    id_ready_and_i = 1'b0;
    cord_i = {4'd1, 4'd2}; cord_v_i = 1'b1;
    @(posedge clk_i); #1 cord_i = {4'd2, 4'd1};
    @(posedge clk_i); #1 cord_i = {4'd2, 4'd2};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      n_cmp++;
      if (cord_ready_and_o !== 1'b0) begin
        n_err++; $display("FAIL stall_ready: got %b required 0", cord_ready_and_o);
      end
      n_cmp++;
      if (id_v_o !== 1'b1 || q.size() != 2) begin
        n_err++; $display("FAIL stall_accepted: id_v=%b queued=%0d required 1 and 2", id_v_o, q.size());
      end
      n_cmp++;
      if (q.size() == 0 || get_resp() !== q[0]) begin
        n_err++; $display("FAIL stall_hold: got %h required first response held", get_resp());
      end
    end
    @(posedge clk_i);
    #1 id_ready_and_i = 1'b1;
    for (int c = 0; c < 20 && got_n < 3; c++) begin
      @(negedge clk_i);
      if (id_v_o) begin
        exp = (q.size() > 0) ? q.pop_front() : 'x;
        n_cmp++;
        if (get_resp() !== exp) begin
          n_err++; $display("FAIL b2b_order_%0d: got %h required %h", got_n, get_resp(), exp);
        end
        got_n++;
      end
      @(posedge clk_i);
      #1 cord_v_i = 1'b0;
    end
    if (got_n < 3) begin
      n_cmp++; n_err++; $display("FAIL b2b_timeout: got %0d responses required 3", got_n);
    end
  endtask

  task automatic test_cfg_same_cycle();
    int got_n = 0;
    resp_t exp;
    cfg_w_v_i  = 1'b1;
    cfg_addr_i = 3'd0;
    cfg_data_i = pack(1'b1, 4'd1, 4'd1, 4'd2, 4'd2, 1'b0, 1'b1, 6'd8, 6'd0);
    cord_i     = {4'd1, 4'd1};
    cord_v_i   = 1'b1;
    @(posedge clk_i);
    #1 cfg_w_v_i = 1'b0; cord_v_i = 1'b0;
    for (int c = 0; c < 20 && got_n < 1; c++) begin
      @(negedge clk_i);
      if (id_v_o) begin
        exp = (q.size() > 0) ? q.pop_front() : 'x;
        n_cmp++;
        if (get_resp() !== exp || cce_id_o !== 6'd0) begin
          n_err++; $display("FAIL cfg_old_entry: got %h required %h (cce 0)", get_resp(), exp);
        end
        got_n++;
      end
      @(posedge clk_i);
      #1;
    end
    lookup(1, 1);
    for (int c = 0; c < 20 && got_n < 2; c++) begin
      @(negedge clk_i);
      if (id_v_o) begin
        exp = (q.size() > 0) ? q.pop_front() : 'x;
        n_cmp++;
        if (get_resp() !== exp || cce_id_o !== 6'd8) begin
          n_err++; $display("FAIL cfg_new_entry: got %h required %h (cce 8)", get_resp(), exp);
        end
        got_n++;
      end
      @(posedge clk_i);
      #1;
    end
    if (got_n < 2) begin
      n_cmp++; n_err++; $display("FAIL cfg_timeout: got %0d responses required 2", got_n);
    end
  endtask

  task automatic test_multi_hit();
    int got_n = 0;
    int xs[8] = '{1, 0, 2, 15, 5, 9, 3, 2};
    int ys[8] = '{1, 0, 0, 0, 5, 9, 3, 2};
    resp_t exp;
    cfg_write(3'd1, pack(1'b1, 4'd0, 4'd0, 4'd3, 4'd3, 1'b1, 1'b0, 6'd20, 6'd30));
    cfg_write(3'd2, pack(1'b1, 4'd14, 4'd0, 4'd3, 4'd1, 1'b0, 1'b0, 6'd40, 6'd50));
    cfg_write(3'd3, pack(1'b1, 4'd5, 4'd5, 4'd0, 4'd1, 1'b0, 1'b0, 6'd60, 6'd0));
    cfg_write(3'd5, pack(1'b1, 4'd9, 4'd9, 4'd1, 4'd1, 1'b0, 1'b0, 6'd1, 6'd1));
    fork
      begin
        for (int i = 0; i < 8; i++) lookup(xs[i], ys[i]);
      end
      begin
        for (int c = 0; c < 60 && got_n < 8; c++) begin
          @(negedge clk_i);
          if (id_v_o) begin
            exp = (q.size() > 0) ? q.pop_front() : 'x;
            n_cmp++;
            if (get_resp() !== exp) begin
              n_err++; $display("FAIL multi_model_%0d: got %h required %h", got_n, get_resp(), exp);
            end
            if (got_n == 0) begin
              n_cmp++;
              if (region_o !== 3'd0 || multi_hit_o !== mh_en || cce_id_o !== 6'd8) begin
                n_err++;
                $display("FAIL overlap_vector: region=%0d multi=%b cce=%0d required 0 %b 8",
                         region_o, multi_hit_o, cce_id_o, mh_en);
              end
            end
            got_n++;
          end
          @(posedge clk_i);
          #1;
        end
      end
    join
    if (got_n < 8) begin
      n_cmp++; n_err++; $display("FAIL multi_timeout: got %0d responses required 8", got_n);
    end
  endtask

  task automatic test_reset_mid();
    int got_n = 0;
    resp_t exp;
    id_ready_and_i = 1'b0;
    lookup(2, 2);
    lookup(1, 1);
    #2 reset_i = 1'b1;
    #1;
    n_cmp++;
    if (id_v_o !== 1'b0) begin
      n_err++; $display("FAIL midreset_id_v: got %b required 0", id_v_o);
    end
    n_cmp++;
    if (get_resp() !== resp_t'(0)) begin
      n_err++; $display("FAIL midreset_outputs: got %h required 0", get_resp());
    end
    q.delete();
    clear_model();
    id_ready_and_i = 1'b1;
    @(posedge clk_i);
    #1 reset_i = 1'b0;
    @(negedge clk_i);
    n_cmp++;
    if (cord_ready_and_o !== 1'b1 || id_v_o !== 1'b0) begin
      n_err++; $display("FAIL midreset_after: ready=%b id_v=%b required 1 0", cord_ready_and_o, id_v_o);
    end
    @(posedge clk_i);
    #1;
    lookup(1, 1);
    for (int c = 0; c < 20 && got_n < 1; c++) begin
      @(negedge clk_i);
      if (id_v_o) begin
        exp = (q.size() > 0) ? q.pop_front() : 'x;
        n_cmp++;
        if (get_resp() !== exp || miss_o !== 1'b1) begin
          n_err++; $display("FAIL midreset_table_cleared: got %h required %h (miss)", get_resp(), exp);
        end
        got_n++;
      end
      @(posedge clk_i);
      #1;
    end
    if (got_n < 1) begin
      n_cmp++; n_err++; $display("FAIL midreset_timeout: got %0d responses required 1", got_n);
    end
  endtask

  initial begin
`ifdef BP_ME_CORD_ID_MAP_MULTI_HIT_EN
    mh_en = 1'b1;
`else
    mh_en = 1'b0;
`endif
    clear_model();
    test_reset();
    test_basic();
    test_miss();
    test_back_to_back();
    test_cfg_same_cycle();
    test_multi_hit();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bp_me_cord_id_map.md
BP_ME_CORD_ID_MAP -- requirements
Module: bp_me_cord_id_map

Interface
REQ-001 SHALL have parameter x_cord_width_p, default 4, meaning mesh x-coordinate width.
REQ-002 SHALL have parameter y_cord_width_p, default 4, meaning mesh y-coordinate width.
REQ-003 SHALL have parameter id_width_p, default 6, meaning CCE/LCE id width.
REQ-004 SHALL have parameter num_regions_p, default 5, meaning programmable region count; region_width_lp = max(1, clog2(num_regions_p)).
REQ-005 SHALL have port clk_i, input, 1, the single clock.
REQ-006 SHALL have port reset_i, input, 1; reset is asynchronous and active-high.
REQ-007 SHALL have port cord_i, input, x+y widths, lookup coordinate: x in low bits, y above.
REQ-008 SHALL have ports cord_v_i (input, 1) and cord_ready_and_o (output, 1), the request handshake.
REQ-009 SHALL have ports cce_id_o, lce_id0_o and lce_id1_o, each output, id_width_p, the translated ids.
REQ-010 SHALL have ports miss_o (output, 1), multi_hit_o (output, 1) and region_o (output, region_width_lp).
REQ-011 SHALL have ports id_v_o (output, 1) and id_ready_and_i (input, 1), the response handshake.
REQ-012 SHALL have ports cfg_w_v_i (input, 1), cfg_addr_i (input, region_width_lp) and cfg_data_i (input, region entry width), the table write port.

Function
REQ-013 Each region entry SHALL hold: v; x_lo; y_lo; x_dim; y_dim; col_major; two_lce; cce_base; lce_base.
REQ-014 Region match SHALL be v & x_lo<=x<x_lo+x_dim & y_lo<=y<y_lo+y_dim, with sums computed one bit wider (no wrap); a dimension of 0 never matches.
REQ-015 On multiple matches, the lowest-index region SHALL win; region_o reports the winning index.
REQ-016 The local index SHALL be computed from lx=x-x_lo and ly=y-y_lo: row-major idx=lx+x_dim*ly, col_major idx=ly+y_dim*lx.
REQ-017 The ids SHALL be cce=cce_base+idx, lce0=lce_base+(idx<<two_lce) and lce1=two_lce ? lce0+1 : lce0, all truncated modulo 2^id_width_p.
REQ-018 On no match, miss_o=1 and all ids and region_o SHALL be 0.
REQ-019 Matching SHALL be evaluated against the table in the accept cycle; stage-1 registers winner and idx, stage-2 registers the final ids.
REQ-020 Latency SHALL be 2 cycles from accept to id_v_o, with throughput of 1 lookup per cycle.
REQ-021 cord_ready_and_o SHALL be ~stage1_v | ~stage2_v | id_ready_and_i; a full pipeline with a stalled output deasserts it.
REQ-022 While id_v_o & ~id_ready_and_i, all outputs SHALL be held stable.
REQ-023 A cfg write SHALL update the entry at the clock edge; a lookup accepted in the same cycle uses the old entry, and in-flight lookups are unaffected.
REQ-024 cfg_addr_i >= num_regions_p SHALL be ignored.

Reset
REQ-025 Reset SHALL clear all entries' v, stage valids, id_v_o, miss_o, multi_hit_o, region_o and all ids to 0.
REQ-026 Reset mid-operation SHALL discard in-flight lookups; cord_ready_and_o=1 on the first cycle after reset deasserts.

Configuration
REQ-027 With BP_ME_CORD_ID_MAP_MULTI_HIT_EN defined, multi_hit_o SHALL be 1 with a response whose coordinate matched two or more regions.
REQ-028 Without BP_ME_CORD_ID_MAP_MULTI_HIT_EN, multi_hit_o SHALL be tied 0 and no overlap logic SHALL be built.

Structure
REQ-029 The region entry struct bp_me_cord_region_s and its width macro SHALL live in bp_me_pkg/bp_me_defines.
REQ-030 A sub-module bp_me_cord_region_match (combinational, one instance per region: match bit plus idx) SHALL be used.

Verification
REQ-031 Region0 set to {1,1,2,2,row,two_lce,0,0}, cord (2,2): after 2 cycles, cce=3, lce0=6, lce1=7, miss=0, region=0.
REQ-032 Cord (0,0) with only region0 valid SHALL give miss_o=1, ids=0 and region_o=0.
REQ-033 With id_ready_and_i=0 and 3 back-to-back requests: 2 SHALL be accepted, cord_ready_and_o=0, and the outputs held; on release all 3 SHALL emerge in order.
REQ-034 A cfg write setting region0 cce_base=8 in the same cycle as a lookup of (1,1): the first response SHALL give cce=0, and the next lookup SHALL give cce=8.
REQ-035 Region1 overlapping region0 at (1,1): region_o=0, and multi_hit_o=1 with the macro or 0 without it; reset asserted mid-stream SHALL give id_v_o=0 immediately.
